// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and decode helpers for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_MULT  = 4'd8;
    localparam logic [3:0] OP_MULTU = 4'd9;
    localparam logic [3:0] OP_DIV   = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_NOR   = 4'd12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // MULT/MULTU/DIV/DIVU occupy codes 8..11.
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes with sign fix-up.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             finished
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q, dvd_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q, dz_q, neg_q, neg_rem_q;

    logic             op_div, op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    logic [WIDTH:0]   sum, shifted, trial;
    logic [WIDTH-1:0] hi_nx, lo_nx;

    always_comb begin
        sum     = {1'b0, acc_hi_q} + {1'b0, opnd_q};
        shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
        trial   = shifted - {1'b0, opnd_q};
        hi_nx   = acc_hi_q;
        lo_nx   = acc_lo_q;
        if (div_q) begin
            // Trial subtract; restore by keeping the shifted remainder on borrow.
            if (!trial[WIDTH]) begin
                hi_nx = trial[WIDTH-1:0];
                lo_nx = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = shifted[WIDTH-1:0];
                lo_nx = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else if (acc_lo_q[0]) begin
            hi_nx = sum[WIDTH:1];
            lo_nx = {sum[0], acc_lo_q[WIDTH-1:1]};
        end else begin
            hi_nx = {1'b0, acc_hi_q[WIDTH-1:1]};
            lo_nx = {acc_hi_q[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            dvd_q     <= '0;
            cnt_q     <= LAST;
            div_q     <= 1'b0;
            dz_q      <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (load) begin
            acc_hi_q  <= '0;
            acc_lo_q  <= op_div ? a_mag : b_mag;
            opnd_q    <= op_div ? b_mag : a_mag;
            dvd_q     <= a;
            cnt_q     <= '0;
            div_q     <= op_div;
            dz_q      <= (b == '0);
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
        end else if (cnt_q != LAST) begin
            acc_hi_q <= hi_nx;
            acc_lo_q <= lo_nx;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    logic [2*WIDTH-1:0] prod, prod_fix;

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign finished = (cnt_q == LAST);

    always_comb begin
        {hi, lo} = prod_fix;
        if (div_q) begin
            if (dz_q) begin
                hi = dvd_q;
                lo = '1;
            end else begin
                hi = neg_rem_q ? -acc_hi_q : acc_hi_q;
                lo = neg_q ? -acc_lo_q : acc_lo_q;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential MIPS-style ALU: single-cycle logic/arith ops plus iterative mul/div into HI/LO.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]       state_q;
    logic [WIDTH-1:0] z_q, hi_q, lo_q, z_alu, md_hi, md_lo;
    logic             done_q, accept, md_load, md_finished;

    assign accept  = start && (state_q != ST_RUN);
    assign md_load = accept && is_muldiv(op);

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .load    (md_load),
        .op      (op),
        .a       (a),
        .b       (b),
        .hi      (md_hi),
        .lo      (md_lo),
        .finished(md_finished)
    );

    always_comb begin
        z_alu = '0;
        case (op)
            OP_AND:  z_alu = a & b;
            OP_OR:   z_alu = a | b;
            OP_ADD:  z_alu = a + b;
            OP_SUB:  z_alu = a - b;
            OP_SLT:  z_alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_NOR:  z_alu = ~(a | b);
            default: z_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (md_finished) begin
                        state_q <= ST_FIN;
                        hi_q    <= md_hi;
                        lo_q    <= md_lo;
                        z_q     <= md_lo;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    // FIN behaves as IDLE for a new start, so busy never blocks it.
                    state_q <= ST_IDLE;
                    if (accept) begin
                        if (is_muldiv(op)) begin
                            state_q <= ST_RUN;
                        end else begin
                            z_q    <= z_alu;
                            done_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign z    = z_q;
    assign zero = (z_q == '0);
    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed table, mul/div corner sequences, randomized model check.
module tb_alu_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [3:0]    op;
    logic [W-1:0]  a, b, z, hi, lo;
    logic          zero, busy, done;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] m_hi, m_lo;

    alu_seq #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .z    (z),
        .zero (zero),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_single(input logic [3:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        case (o)
            4'd0:    return x & y;
            4'd1:    return x | y;
            4'd2:    return x + y;
            4'd6:    return x - y;
            4'd7:    return ($signed(x) < $signed(y)) ? 1 : 0;
            4'd12:   return ~(x | y);
            default: return '0;
        endcase
    endfunction

    // Returns {hi, lo} computed with wide integer arithmetic.
    function automatic logic [2*W-1:0] ref_md(input logic [3:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        logic signed [2*W-1:0] sx, sy, sq, sr;
        logic [2*W-1:0] ux, uy, uq, ur;
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        ux = {{W{1'b0}}, x};
        uy = {{W{1'b0}}, y};
        if (o == 4'd8) return sx * sy;
        if (o == 4'd9) return ux * uy;
        if (y == '0) return {x, {W{1'b1}}};
        if (o == 4'd10) begin
            sq = sx / sy;
            sr = sx % sy;
            return {sr[W-1:0], sq[W-1:0]};
        end
        uq = ux / uy;
        ur = ux % uy;
        return {ur[W-1:0], uq[W-1:0]};
    endfunction

    task automatic run_md(input string name, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [2*W-1:0] exp, input int inject_at);
        int early;
        early = 0;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= W + 1; i++) begin
            if (i == inject_at) begin
                start = 1'b1; op = 4'd2; a = 32'd1; b = 32'd2;
            end
            tick();
            start = 1'b0;
            if (i <= W && (done || !busy)) early++;
        end
        chk({name, ".early"}, early, 0);
        chk({name, ".done"}, {31'b0, done}, 1);
        chk({name, ".busy"}, {31'b0, busy}, 0);
        chk({name, ".hi"}, hi, exp[2*W-1:W]);
        chk({name, ".lo"}, lo, exp[W-1:0]);
        chk({name, ".z"}, z, exp[W-1:0]);
        m_hi = exp[2*W-1:W];
        m_lo = exp[W-1:0];
        tick();
        chk({name, ".done_pulse"}, {31'b0, done}, 0);
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] z;
        logic         zero;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int ndone;
        logic [3:0] o;
        logic [W-1:0] x, y, ez;
        logic [3:0] sops[9];

        tbl[0]  = '{4'd6,  32'd5,          32'd5,          32'd0,          1'b1};
        tbl[1]  = '{4'd0,  32'd21,         32'd3,          32'd1,          1'b0};
        tbl[2]  = '{4'd7,  32'd1,          32'd3,          32'd1,          1'b0};
        tbl[3]  = '{4'd7,  32'd6,          32'd5,          32'd0,          1'b1};
        tbl[4]  = '{4'd7,  32'hFFFFFFFF,   32'd0,          32'd1,          1'b0};
        tbl[5]  = '{4'd12, 32'd0,          32'd0,          32'hFFFFFFFF,   1'b0};
        tbl[6]  = '{4'd3,  32'd9,          32'd4,          32'd0,          1'b1};
        tbl[7]  = '{4'd2,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b1};
        tbl[8]  = '{4'd6,  32'd0,          32'd1,          32'hFFFFFFFF,   1'b0};
        tbl[9]  = '{4'd1,  32'hF0F00000,   32'h0000000F,   32'hF0F0000F,   1'b0};
        tbl[10] = '{4'd13, 32'd1,          32'd1,          32'd0,          1'b1};

        sops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd5, 4'd15};

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst.z", z, 0);
        chk("rst.zero", {31'b0, zero}, 1);
        chk("rst.busy", {31'b0, busy}, 0);
        chk("rst.done", {31'b0, done}, 0);
        chk("rst.hi", hi, 0);
        chk("rst.lo", lo, 0);

        // Back-to-back single-cycle ops, one start per cycle.
        for (int i = 0; i < 11; i++) begin
            op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; start = 1'b1;
            tick();
            chk($sformatf("tbl%0d.z", i), z, tbl[i].z);
            chk($sformatf("tbl%0d.zero", i), {31'b0, zero}, {31'b0, tbl[i].zero});
            chk($sformatf("tbl%0d.done", i), {31'b0, done}, 1);
            chk($sformatf("tbl%0d.busy", i), {31'b0, busy}, 0);
        end
        start = 1'b0;
        tick();
        chk("tbl.idle_done", {31'b0, done}, 0);
        chk("tbl.hi_untouched", hi, m_hi);
        chk("tbl.lo_untouched", lo, m_lo);

        run_md("mult", 4'd8, 32'hFFFFFFF9, 32'd6, 64'hFFFFFFFF_FFFFFFD6, 0);
        run_md("multu", 4'd9, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 0);
        run_md("div", 4'd10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);
        run_md("divu0", 4'd11, 32'd7, 32'd0, 64'h00000007_FFFFFFFF, 0);
        run_md("divmin", 4'd10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0);
        run_md("div_inject", 4'd10, 32'd100, 32'd7, 64'h00000002_0000000E, 5);

        // Single op after mul/div leaves hi/lo alone.
        op = 4'd2; a = 32'd40; b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("post.z", z, 32'd42);
        chk("post.hi", hi, m_hi);
        chk("post.lo", lo, m_lo);

        // Reset in the middle of a divide aborts it.
        op = 4'd10; a = 32'hFFFFFF9C; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort.busy", {31'b0, busy}, 0);
        chk("abort.hi", hi, 0);
        chk("abort.lo", lo, 0);
        chk("abort.z", z, 0);
        chk("abort.zero", {31'b0, zero}, 1);
        ndone = 0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        chk("abort.no_done", ndone, 0);
        m_hi = '0; m_lo = '0;

        for (int i = 0; i < 24; i++) begin
            o = sops[$urandom_range(0, 8)];
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? x : $urandom;
            ez = ref_single(o, x, y);
            op = o; a = x; b = y; start = 1'b1;
            tick();
            start = 1'b0;
            chk($sformatf("rnd%0d.op%0d.z", i, o), z, ez);
            chk($sformatf("rnd%0d.zero", i), {31'b0, zero}, {31'b0, ez == '0});
            chk($sformatf("rnd%0d.done", i), {31'b0, done}, 1);
        end
        chk("rnd.hi_untouched", hi, m_hi);

        for (int i = 0; i < 10; i++) begin
            o = 4'd8 + 4'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 4))
                0:       y = '0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = 32'hFFFFFFFF;
                default: y = $urandom;
            endcase
            if (i == 0) x = 32'h80000000;
            run_md($sformatf("rmd%0d.op%0d", i, o), o, x, y, ref_md(o, x, y), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
